// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and FSM state encoding for the fetch sequencer
package fetch_pkg;
    localparam int MEM_DEPTH = 1000;
    localparam int PC_W = 10;
    localparam int INST_W = 32;
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(MEM_DEPTH - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] HALT = 2'd3;
endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: 2-entry {pc, inst} buffer with registered head, push/pop/flush
module fetch_fifo2
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [PC_W-1:0]   wpc,
    input  logic [INST_W-1:0] wdata,
    output logic              valid,
    output logic [PC_W-1:0]   head_pc,
    output logic [INST_W-1:0] head,
    output logic [1:0]        occ
);
    logic [PC_W+INST_W-1:0] e0, e1, w;
    logic take;
    assign w = {wpc, wdata};
    assign take = pop && occ != 2'd0;
    assign valid = occ != 2'd0;
    assign {head_pc, head} = e0;
    // entry 0 is always the head; entry 1 shifts forward on a pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0 <= '0;
            e1 <= '0;
            occ <= 2'd0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, take};
            e0 <= (take && occ == 2'd2) ? e1 : (push && (take || occ == 2'd0)) ? w : e0;
            if (push && (occ == 2'd2 ? take : (occ == 2'd1 && !take))) e1 <= w;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC generation, in-flight read tracking and decode handoff
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   imem_pc,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);
    logic [1:0] state, occ, load;
    logic [PC_W-1:0] pc, ipc;
    logic inflight, pop, redir, issue, can_start;
    assign imem_pc = pc;
    assign busy = state == FETCH || state == DRAIN;
    assign halted = state == HALT;
    assign pop = inst_valid && inst_ready;
    assign redir = redirect_valid && busy;
    assign can_start = start && (state == IDLE || state == HALT);
    assign load = occ + {1'b0, inflight};
    assign issue = state == FETCH && !redirect_valid && (load < 2'd2 || pop);

    fetch_fifo2 u_fifo (
        .clk(clk),
        .rst(rst),
        .push(inflight && !redir),
        .pop(pop && !redir),
        .flush(redir),
        .wpc(ipc),
        .wdata(imem_rdata),
        .valid(inst_valid),
        .head_pc(inst_pc),
        .head(inst),
        .occ(occ)
    );

    // controller: redirect beats start, pc stops at the last word instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc <= '0;
            ipc <= '0;
            inflight <= 1'b0;
            err <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) ipc <= pc;
            if (redir) begin
                if (redirect_pc <= LAST_PC) begin
                    pc <= redirect_pc;
                    state <= FETCH;
                end else begin
                    err <= 1'b1;
                    state <= HALT;
                end
            end else if (can_start) begin
                if (start_pc <= LAST_PC) begin
                    pc <= start_pc;
                    state <= FETCH;
                end else begin
                    err <= 1'b1;
                    state <= HALT;
                end
            end else if (issue) begin
                if (pc == LAST_PC) state <= DRAIN;
                else pc <= pc + 1'b1;
            end else if (state == DRAIN && !inflight && occ == 2'd0) begin
                state <= HALT;
            end
        end
    end
endmodule
